// File: rtl/du_regfile_dump_ctrl.sv
// Debug-unit register file dump sequencer.
// Walks registers 0..NUM_REGS-1 and streams each word MSB first as bytes.
module du_regfile_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [31:0]       i_du_reg_data,
  input  logic              i_tx_ready,
  output logic [ADDR_W-1:0] o_du_reg_addr,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              xfer;

  assign xfer = (state_q == S_SEND) && i_tx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (i_start && !i_abort) state_d = S_ADDR;
      end
      S_ADDR: begin
        word_d  = i_du_reg_data;
        cnt_d   = 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (cnt_q != 2'd3) begin
            word_d = word_q << 8;
            cnt_d  = cnt_q + 2'd1;
          end else if (addr_q != LAST) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition once a dump is under way.
    if (i_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_du_reg_addr = addr_q;
  assign o_tx_data     = word_q[31:24];
  assign o_tx_valid    = (state_q == S_SEND);
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);

endmodule

// File: tb/tb_du_regfile_dump_ctrl.sv
// Directed bench for du_regfile_dump_ctrl.
// Runs a 32-register instance and a 4-register instance.
module tb_du_regfile_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sel;
  logic start_m, abort_m, ready_m;

  logic [4:0]  addr1;
  logic [1:0]  addr2;
  logic [31:0] rd1, rd2;
  logic [7:0]  data1, data2;
  logic        v1, v2, b1, b2, d1, d2;

  logic [4:0]  addr_m;
  logic [7:0]  data_m;
  logic        valid_m, busy_m, done_m;

  int n_cmp = 0;
  int n_err = 0;

  assign rd1 = 32'h01020300 + {27'd0, addr1};
  assign rd2 = (addr2 == 2'd3) ? 32'hDEADBEEF
                               : 32'h01020300 + {30'd0, addr2};

  du_regfile_dump_ctrl #(.NUM_REGS(32), .ADDR_W(5)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_start(start_m && !sel), .i_abort(abort_m && !sel),
    .i_du_reg_data(rd1), .i_tx_ready(ready_m),
    .o_du_reg_addr(addr1), .o_tx_data(data1), .o_tx_valid(v1),
    .o_busy(b1), .o_done(d1)
  );

  du_regfile_dump_ctrl #(.NUM_REGS(4), .ADDR_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst),
    .i_start(start_m && sel), .i_abort(abort_m && sel),
    .i_du_reg_data(rd2), .i_tx_ready(ready_m),
    .o_du_reg_addr(addr2), .o_tx_data(data2), .o_tx_valid(v2),
    .o_busy(b2), .o_done(d2)
  );

  assign addr_m  = sel ? {3'd0, addr2} : addr1;
  assign data_m  = sel ? data2 : data1;
  assign valid_m = sel ? v2 : v1;
  assign busy_m  = sel ? b2 : b1;
  assign done_m  = sel ? d2 : d1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    int r, b;
    r = n / 4;
    b = n % 4;
    if (sel && r == 3) w = 32'hDEADBEEF;
    else w = 32'h01020300 + r;
    return 8'(w >> (24 - 8 * b));
  endfunction

  task automatic run(input bit toggle, input int glitch,
                     input int abort_at, output int nb,
                     output int nd, output int dcyc, output int bcyc);
    logic pv, pr;
    logic [7:0] pd;
    bit ended;
    nb = 0; nd = 0; dcyc = 0; bcyc = 0;
    pv = 0; pr = 0; pd = 0; ended = 0;
    start_m = 1; ready_m = 1; abort_m = 0;
    @(negedge clk);
    start_m = 0;
    for (int c = 1; c < 1000 && !ended; c++) begin
      if (busy_m) bcyc++;
      if (done_m) begin nd++; dcyc = c; end
      if (pv && !pr && valid_m) chk("hold_data", data_m, pd);
      ready_m = toggle ? (c % 3 == 1) : 1'b1;
      start_m = (c == glitch);
      abort_m = valid_m && (nb == abort_at);
      if (abort_m) ready_m = 1'b1;
      if (valid_m && ready_m) begin
        chk($sformatf("byte%0d", nb), data_m, exp_byte(nb));
        nb++;
      end
      pv = valid_m; pr = ready_m; pd = data_m;
      if (abort_m) begin
        @(negedge clk);
        abort_m = 0;
        ended = 1;
      end else if (!busy_m && c > 1) begin
        ended = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ended) chk("run_timeout", 0, 1);
    start_m = 0;
    ready_m = 1;
  endtask

  int nb, nd, dc, bc;

  initial begin
    sel = 0; start_m = 0; abort_m = 0; ready_m = 1;
    rst = 1;
    #1;
    chk("rst_busy", busy_m, 0);
    chk("rst_valid", valid_m, 0);
    chk("rst_addr", addr_m, 0);
    chk("rst_data", data_m, 0);
    chk("rst_done", done_m, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    run(0, -1, -1, nb, nd, dc, bc);
    chk("full_bytes", nb, 128);
    chk("full_done_cnt", nd, 1);
    chk("full_done_cyc", dc, 161);
    chk("full_busy_cyc", bc, 161);
    chk("full_idle_addr", addr_m, 0);

    run(1, -1, -1, nb, nd, dc, bc);
    chk("tog_bytes", nb, 128);
    chk("tog_done_cnt", nd, 1);

    run(0, -1, 22, nb, nd, dc, bc);
    chk("abort_bytes", nb, 23);
    chk("abort_done_cnt", nd, 0);
    chk("abort_busy", busy_m, 0);
    chk("abort_valid", valid_m, 0);
    chk("abort_addr", addr_m, 0);
    chk("abort_done", done_m, 0);
    @(negedge clk);
    chk("abort_done2", done_m, 0);

    abort_m = 1; start_m = 1;
    @(negedge clk);
    abort_m = 0; start_m = 0;
    chk("idle_abort_start", busy_m, 0);

    run(0, -1, -1, nb, nd, dc, bc);
    chk("restart_bytes", nb, 128);

    run(0, 40, -1, nb, nd, dc, bc);
    chk("glitch_bytes", nb, 128);
    chk("glitch_done_cnt", nd, 1);
    chk("glitch_done_cyc", dc, 161);

    start_m = 1;
    @(negedge clk);
    start_m = 0;
    for (int i = 0; i < 200 && addr_m != 5'd10; i++) @(negedge clk);
    chk("reach_r10", addr_m, 10);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy_m, 0);
    chk("arst_valid", valid_m, 0);
    chk("arst_addr", addr_m, 0);
    chk("arst_data", data_m, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(0, -1, -1, nb, nd, dc, bc);
    chk("post_rst_bytes", nb, 128);

    sel = 1;
    @(negedge clk);
    run(0, -1, -1, nb, nd, dc, bc);
    chk("n4_bytes", nb, 16);
    chk("n4_done_cnt", nd, 1);
    chk("n4_done_cyc", dc, 21);
    chk("n4_busy_cyc", bc, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
